tx_iq_packer: RTL and testbench
===============================

TX_IQ_PACKER -- requirements
Module: tx_iq_packer

Interface
REQ-001 Parameter LEVEL_W, default 14: width of the fifo_level input.
REQ-002 Parameter HIGH_WATER, default 15360: fifo_level at or above which tx_allow is deasserted.
REQ-003 clk  input  1  single clock, clk_internal domain; all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 word_tdata  input  32  TX IQ word as {I[15:0], Q[15:0]}, 16-bit signed each.
REQ-006 word_tvalid  input  1  one-cycle strobe (already synchronised SPI-done); word_tdata is valid in that cycle.
REQ-007 enable  input  1  transmit gate, driven by cmd_ptt | cwx_enabled.
REQ-008 clear_status  input  1  one-cycle pulse that clears overflow_cnt.
REQ-009 fifo_tdata  output  9  byte to dsiq_fifo; bit 8 is always 0.
REQ-010 fifo_tvalid  output  1  fifo_tdata is valid.
REQ-011 fifo_tready  input  1  the FIFO accepts the byte.
REQ-012 fifo_tlast  output  1  high on the last byte (Q[7:0]) of each word.
REQ-013 fifo_level  input  LEVEL_W  FIFO fill level in bytes.
REQ-014 tx_allow  output  1  the driver may send the next word.
REQ-015 overflow_cnt  output  16  saturating count of dropped words.

Function
REQ-016 States: IDLE, B3, B2, B1, B0; the state register is the only control state besides the hold register.
REQ-017 Byte order: B3 = I[15:8], B2 = I[7:0], B1 = Q[15:8], B0 = Q[7:0].
REQ-018 fifo_tvalid is 1 exactly in states B3..B0; fifo_tlast is 1 only in B0.
REQ-019 Advance B3->B2->B1->B0 only on the cycle where fifo_tvalid and fifo_tready are both 1; otherwise hold state and fifo_tdata stable.
REQ-020 Word acceptance (IDLE, enable=1, word_tvalid=1):
- word loaded into the shift register;
- next cycle is B3.
- Latency from strobe to first fifo_tvalid is 1 cycle.
REQ-021 Word while busy (B3..B0, enable=1, word_tvalid=1):
- stored in the 1-deep hold register if it is empty;
- if the hold register is full, the word is dropped and overflow_cnt increments.
REQ-022 B0 handshake completes, hold register full: load the held word, empty the hold register, go to B3 next cycle with no bubble.
REQ-023 B0 handshake completes, hold register empty, word_tvalid=1 with enable=1 in the same cycle: load that word directly, go to B3.
REQ-024 B0 handshake completes with no word pending: go to IDLE.
REQ-025 word_tvalid while enable=0: word discarded and not counted in overflow_cnt.
REQ-026 enable falling mid-word: finish the current word through B0 (no partial words enter the FIFO), clear the hold register, then go to IDLE.
REQ-027 tx_allow = 1 when (fifo_level < HIGH_WATER) and the hold register is empty; registered, updated every cycle.
REQ-028 overflow_cnt saturates at 16'hFFFF.
REQ-029 clear_status coinciding with an overflow event: clear wins, overflow_cnt = 0.
REQ-030 fifo_tready is ignored in IDLE.

Reset
REQ-031 On rst=1 at a clock edge, the block takes its reset state on that edge regardless of the current state:
- state = IDLE;
- hold register empty;
- fifo_tvalid = 0, fifo_tlast = 0, fifo_tdata = 0;
- overflow_cnt = 0, tx_allow = 0.
REQ-032 rst asserted mid-word abandons the word with no further bytes issued; tx_allow returns to its normal function the first cycle after rst deasserts.

Verification
REQ-033 Single word: enable=1, word 0x12345678, fifo_tready=1 -> fifo_tdata 0x012,0x034,0x056,0x078 on 4 consecutive cycles, starting 1 cycle after the strobe; fifo_tlast only on 0x078.
REQ-034 Backpressure: same word, fifo_tready low for 3 cycles during B2 -> 0x034 held stable for those 3 cycles; bytes issued in order; no duplicate bytes.
REQ-035 Overflow and back-to-back:
- three strobes (0xAAAA5555, 0x11112222, 0x33334444) 1 cycle apart with fifo_tready=0;
- then fifo_tready=1;
- expected: first two words emitted back-to-back (8 bytes, no bubble); third word dropped; overflow_cnt=1.
REQ-036 Gating:
- word strobe with enable=0 -> no fifo_tvalid, overflow_cnt unchanged;
- enable dropped during B2 -> remaining B1 and B0 bytes still issued, then IDLE.
REQ-037 Flow control:
- fifo_level = 15359 -> tx_allow=1; fifo_level = 15360 -> tx_allow=0;
- hold register full -> tx_allow=0.
REQ-038 Reset and clear:
- rst pulsed in B1 -> fifo_tvalid=0 the next cycle, overflow_cnt=0;
- clear_status coinciding with an overflow -> overflow_cnt=0.

Source files
------------

// File: rtl/tx_iq_packer.sv
// Serialises 32-bit TX IQ words into four bytes for the DSIQ FIFO.
// A one-word hold register absorbs a strobe that arrives while a word is still going out.
module tx_iq_packer #(
    parameter int LEVEL_W    = 14,
    parameter int HIGH_WATER = 15360
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        word_tdata,
    input  logic               word_tvalid,
    input  logic               enable,
    input  logic               clear_status,
    output logic [8:0]         fifo_tdata,
    output logic               fifo_tvalid,
    input  logic               fifo_tready,
    output logic               fifo_tlast,
    input  logic [LEVEL_W-1:0] fifo_level,
    output logic               tx_allow,
    output logic [15:0]        overflow_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        B3,
        B2,
        B1,
        B0
    } state_t;

    localparam logic [LEVEL_W-1:0] HIGH_LEVEL = LEVEL_W'(HIGH_WATER);

    state_t      state;
    state_t      state_next;
    logic [31:0] shift_reg;
    logic [31:0] hold_reg;
    logic        hold_valid;

    logic busy;
    logic accept;
    logic end_word;
    logic load_new;
    logic load_held;
    logic shift_en;
    logic hold_set;
    logic hold_clr;
    logic drop;

    assign busy     = (state != IDLE);
    assign accept   = enable && word_tvalid;
    assign end_word = (state == B0) && fifo_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_new   = 1'b0;
        load_held  = 1'b0;
        shift_en   = 1'b0;
        hold_set   = 1'b0;
        hold_clr   = 1'b0;
        drop       = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    load_new   = 1'b1;
                    state_next = B3;
                end
            end
            B3: begin
                if (fifo_tready) begin
                    shift_en   = 1'b1;
                    state_next = B2;
                end
            end
            B2: begin
                if (fifo_tready) begin
                    shift_en   = 1'b1;
                    state_next = B1;
                end
            end
            B1: begin
                if (fifo_tready) begin
                    shift_en   = 1'b1;
                    state_next = B0;
                end
            end
            B0: begin
                if (fifo_tready) begin
                    shift_en = 1'b1;
                    // With the gate closed the finished word is the last one; anything held is abandoned.
                    if (!enable) begin
                        hold_clr   = 1'b1;
                        state_next = IDLE;
                    end else if (hold_valid) begin
                        load_held  = 1'b1;
                        hold_clr   = 1'b1;
                        state_next = B3;
                    end else if (word_tvalid) begin
                        load_new   = 1'b1;
                        state_next = B3;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A strobe while busy goes to the hold register, unless the closing B0 handshake takes it directly.
        if (busy && accept) begin
            if (hold_valid) begin
                drop = 1'b1;
            end else if (!end_word) begin
                hold_set = 1'b1;
            end
        end
    end

    assign fifo_tvalid = busy;
    assign fifo_tlast  = (state == B0);
    assign fifo_tdata  = busy ? {1'b0, shift_reg[31:24]} : 9'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg    <= 32'd0;
            hold_reg     <= 32'd0;
            hold_valid   <= 1'b0;
            overflow_cnt <= 16'd0;
            tx_allow     <= 1'b0;
        end else begin
            if (load_new) begin
                shift_reg <= word_tdata;
            end else if (load_held) begin
                shift_reg <= hold_reg;
            end else if (shift_en) begin
                shift_reg <= {shift_reg[23:0], 8'h00};
            end

            if (hold_set) begin
                hold_reg   <= word_tdata;
                hold_valid <= 1'b1;
            end else if (hold_clr) begin
                hold_valid <= 1'b0;
            end

            if (clear_status) begin
                overflow_cnt <= 16'd0;
            end else if (drop && (overflow_cnt != 16'hFFFF)) begin
                overflow_cnt <= overflow_cnt + 16'd1;
            end

            tx_allow <= (fifo_level < HIGH_LEVEL) && !hold_valid;
        end
    end

endmodule

// File: tb/tb_tx_iq_packer.sv
// Bench for tx_iq_packer: directed scenarios followed by random traffic, all checked
// against a byte-queue reference model of the packer.
module tb_tx_iq_packer;

    localparam int LEVEL_W    = 14;
    localparam int HIGH_WATER = 15360;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        word_tdata;
    logic               word_tvalid;
    logic               enable;
    logic               clear_status;
    logic [8:0]         fifo_tdata;
    logic               fifo_tvalid;
    logic               fifo_tready;
    logic               fifo_tlast;
    logic [LEVEL_W-1:0] fifo_level;
    logic               tx_allow;
    logic [15:0]        overflow_cnt;

    tx_iq_packer #(
        .LEVEL_W   (LEVEL_W),
        .HIGH_WATER(HIGH_WATER)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .word_tdata  (word_tdata),
        .word_tvalid (word_tvalid),
        .enable      (enable),
        .clear_status(clear_status),
        .fifo_tdata  (fifo_tdata),
        .fifo_tvalid (fifo_tvalid),
        .fifo_tready (fifo_tready),
        .fifo_tlast  (fifo_tlast),
        .fifo_level  (fifo_level),
        .tx_allow    (tx_allow),
        .overflow_cnt(overflow_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: bytes still to leave for the current word, the held word, counter, tx_allow.
    logic [7:0]  cur_q[$];
    logic [31:0] hold_q[$];
    logic [15:0] m_cnt;
    logic        m_allow;

    logic [9:0]  seen_q[$];
    int          seen_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [31:0] w);
        cur_q = {w[31:24], w[23:16], w[15:8], w[7:0]};
    endtask

    task automatic model_step();
        logic acc;
        logic was_busy;
        logic finishing;
        logic direct;
        if (rst) begin
            cur_q.delete();
            hold_q.delete();
            m_cnt   = 16'd0;
            m_allow = 1'b0;
            return;
        end
        m_allow   = (int'(fifo_level) < HIGH_WATER) && (hold_q.size() == 0);
        acc       = enable && word_tvalid;
        was_busy  = (cur_q.size() != 0);
        finishing = was_busy && fifo_tready && (cur_q.size() == 1);
        direct    = 1'b0;
        if (clear_status) begin
            m_cnt = 16'd0;
        end else if (was_busy && acc && (hold_q.size() != 0) && (m_cnt != 16'hFFFF)) begin
            m_cnt = m_cnt + 16'd1;
        end
        if (!was_busy) begin
            if (acc) load_word(word_tdata);
        end else begin
            if (acc && (hold_q.size() == 0)) begin
                if (finishing) direct = 1'b1;
                else hold_q.push_back(word_tdata);
            end
            if (fifo_tready) void'(cur_q.pop_front());
            if (finishing) begin
                if (!enable) hold_q.delete();
                else if (hold_q.size() != 0) load_word(hold_q.pop_front());
                else if (direct) load_word(word_tdata);
            end
        end
    endtask

    task automatic checkOutput();
        check("tvalid", 32'(fifo_tvalid), 32'(cur_q.size() != 0));
        if (cur_q.size() != 0) begin
            check("tdata", 32'(fifo_tdata), {23'd0, 1'b0, cur_q[0]});
            check("tlast", 32'(fifo_tlast), 32'(cur_q.size() == 1));
        end else begin
            check("tlast_idle", 32'(fifo_tlast), 32'd0);
        end
        check("overflow_cnt", 32'(overflow_cnt), 32'(m_cnt));
        check("tx_allow", 32'(tx_allow), 32'(m_allow));
    endtask

    // One clock: check outputs, log any accepted byte, advance the model, step past the edge.
    task automatic applyStimulus();
        checkOutput();
        if (fifo_tvalid && fifo_tready && !rst) begin
            seen_q.push_back({fifo_tlast, fifo_tdata});
            seen_cyc.push_back(cyc);
        end
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic strobe(input logic [31:0] w);
        word_tdata  = w;
        word_tvalid = 1'b1;
        applyStimulus();
        word_tvalid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) applyStimulus();
    endtask

    task automatic check_seq(input string tag, input logic [31:0] w0, input logic [31:0] w1, input int nwords);
        logic [9:0]  exp_q[$];
        logic [31:0] w;
        for (int k = 0; k < nwords; k++) begin
            w = (k == 0) ? w0 : w1;
            exp_q.push_back({2'b00, w[31:24]});
            exp_q.push_back({2'b00, w[23:16]});
            exp_q.push_back({2'b00, w[15:8]});
            exp_q.push_back({2'b10, w[7:0]});
        end
        check({tag, "_count"}, 32'(seen_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < seen_q.size(); k++) begin
            check(tag, 32'(seen_q[k]), 32'(exp_q[k]));
        end
    endtask

    initial begin
        rst          = 1'b1;
        word_tdata   = 32'd0;
        word_tvalid  = 1'b0;
        enable       = 1'b0;
        clear_status = 1'b0;
        fifo_tready  = 1'b0;
        fifo_level   = '0;
        repeat (2) @(posedge clk);
        #1;
        cur_q.delete();
        hold_q.delete();
        m_cnt   = 16'd0;
        m_allow = 1'b0;
        check("reset_tvalid", 32'(fifo_tvalid), 32'd0);
        check("reset_tlast", 32'(fifo_tlast), 32'd0);
        check("reset_tdata", 32'(fifo_tdata), 32'd0);
        check("reset_cnt", 32'(overflow_cnt), 32'd0);
        check("reset_allow", 32'(tx_allow), 32'd0);
        rst = 1'b0;
        run(2);

        $display("[TB] single word");
        enable      = 1'b1;
        fifo_tready = 1'b1;
        seen_q.delete();
        strobe(32'h12345678);
        run(6);
        check_seq("single_word", 32'h12345678, 32'h0, 1);

        $display("[TB] backpressure in B2");
        seen_q.delete();
        strobe(32'h12345678);
        run(1);
        fifo_tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("bp_hold_data", 32'(fifo_tdata), 32'h034);
            applyStimulus();
        end
        fifo_tready = 1'b1;
        run(5);
        check_seq("backpressure", 32'h12345678, 32'h0, 1);

        $display("[TB] overflow and back-to-back");
        seen_q.delete();
        seen_cyc.delete();
        fifo_tready = 1'b0;
        strobe(32'hAAAA5555);
        strobe(32'h11112222);
        strobe(32'h33334444);
        check("ovf_cnt_one", 32'(overflow_cnt), 32'd1);
        check("ovf_allow_hold_full", 32'(tx_allow), 32'd0);
        fifo_tready = 1'b1;
        run(10);
        check_seq("back_to_back", 32'hAAAA5555, 32'h11112222, 2);
        if (seen_cyc.size() == 8) check("no_bubble", 32'(seen_cyc[7] - seen_cyc[0]), 32'd7);

        $display("[TB] gating");
        seen_q.delete();
        enable = 1'b0;
        strobe(32'hDEADBEEF);
        run(3);
        check("gated_no_bytes", 32'(seen_q.size()), 32'd0);
        check("gated_cnt", 32'(overflow_cnt), 32'd1);
        enable = 1'b1;
        strobe(32'hCAFEF00D);
        run(1);
        enable = 1'b0;
        run(5);
        check_seq("enable_drop", 32'hCAFEF00D, 32'h0, 1);
        check("enable_drop_idle", 32'(fifo_tvalid), 32'd0);

        $display("[TB] flow control");
        enable     = 1'b1;
        fifo_level = LEVEL_W'(HIGH_WATER - 1);
        run(1);
        check("allow_below_hw", 32'(tx_allow), 32'd1);
        fifo_level = LEVEL_W'(HIGH_WATER);
        run(1);
        check("allow_at_hw", 32'(tx_allow), 32'd0);
        fifo_level = '0;
        run(1);

        $display("[TB] clear with overflow");
        fifo_tready = 1'b0;
        strobe(32'h01020304);
        strobe(32'h05060708);
        strobe(32'h090A0B0C);
        check("clr_pre_cnt", 32'(overflow_cnt), 32'd2);
        clear_status = 1'b1;
        strobe(32'h0D0E0F10);
        clear_status = 1'b0;
        check("clr_wins", 32'(overflow_cnt), 32'd0);
        fifo_tready = 1'b1;
        run(12);

        $display("[TB] reset in B1");
        fifo_tready = 1'b0;
        strobe(32'h11223344);
        strobe(32'h55667788);
        strobe(32'h99AABBCC);
        fifo_tready = 1'b1;
        run(2);
        seen_q.delete();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        check("rst_tvalid", 32'(fifo_tvalid), 32'd0);
        check("rst_cnt", 32'(overflow_cnt), 32'd0);
        run(1);
        check("rst_allow_back", 32'(tx_allow), 32'd1);
        run(4);
        check("rst_no_bytes", 32'(seen_q.size()), 32'd0);

        $display("[TB] random traffic");
        for (int k = 0; k < 3000; k++) begin
            rst          = ($urandom % 400) == 0;
            enable       = ($urandom % 8) != 0;
            word_tvalid  = ($urandom % 3) == 0;
            word_tdata   = $urandom;
            fifo_tready  = ($urandom % 4) != 0;
            clear_status = ($urandom % 60) == 0;
            fifo_level   = (($urandom % 2) == 0) ? LEVEL_W'($urandom_range(HIGH_WATER - 4, HIGH_WATER + 4))
                                                 : LEVEL_W'($urandom_range(0, HIGH_WATER - 1));
            applyStimulus();
        end
        rst         = 1'b0;
        word_tvalid = 1'b0;
        run(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
